// File: rtl/ctrl_pool_wb.sv
// Pool-stage write-back controller: raster pixels -> output buffer addresses, done/err reporting.
// Write has 1-cycle registered latency. No backpressure. Optional macro: CTRL_POOL_WB_PITCH_EN.
module ctrl_pool_wb #(
  parameter int LWIDTH = 10,
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 12
) (
  input  logic              clk,
  input  logic              xrst,
  input  logic              in_begin,
  input  logic              in_valid,
  input  logic              in_end,
  input  logic [DWIDTH-1:0] in_data,
  input  logic [LWIDTH-1:0] out_size,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [LWIDTH-1:0] out_pitch,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic {S_WAIT, S_ACTIVE} state_t;

  localparam int CWIDTH = 2 * LWIDTH;
  localparam logic [CWIDTH-1:0] CNT_ONE = CWIDTH'(1);
  localparam logic [LWIDTH-1:0] X_ONE   = LWIDTH'(1);

  state_t              r_state, w_state_nxt;
  logic [LWIDTH-1:0]   r_n;
  logic [LWIDTH-1:0]   r_x;
  logic [AWIDTH-1:0]   r_row_base;
  logic [CWIDTH-1:0]   r_cnt;
  logic                r_we;
  logic [AWIDTH-1:0]   r_addr;
  logic [DWIDTH-1:0]   r_wdata;
  logic                r_done;
  logic                r_err;

  logic                w_start;
  logic                w_accept;
  logic                w_ovf;
  logic                w_finish;
  logic [CWIDTH-1:0]   w_nn;
  logic                w_count_ok;
  logic [AWIDTH-1:0]   w_stride;

`ifdef CTRL_POOL_WB_PITCH_EN
  logic [LWIDTH-1:0]   r_pitch;
  always_ff @(posedge clk) begin
    if (xrst) begin
      r_pitch <= '0;
    end else if (w_start) begin
      r_pitch <= out_pitch;
    end
  end
  assign w_stride = AWIDTH'(r_pitch);
`else
  logic w_unused_pitch;
  assign w_unused_pitch = ^out_pitch;
  assign w_stride       = AWIDTH'(r_n);
`endif

  assign w_nn = {{LWIDTH{1'b0}}, r_n} * {{LWIDTH{1'b0}}, r_n};

  // A coincident final pixel counts toward the frame total checked at in_end.
  assign w_count_ok = w_accept ? ((r_cnt + CNT_ONE) == w_nn) : (r_cnt == w_nn);

  always_ff @(posedge clk) begin
    if (xrst) begin
      r_state <= S_WAIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_accept    = 1'b0;
    w_ovf       = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_WAIT: begin
        if (in_begin) begin
          w_start     = 1'b1;
          w_state_nxt = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (in_valid) begin
          if (r_cnt < w_nn) begin
            w_accept = 1'b1;
          end else begin
            w_ovf = 1'b1;
          end
        end
        if (in_end) begin
          w_finish    = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      default: w_state_nxt = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (xrst) begin
      r_n        <= '0;
      r_x        <= '0;
      r_row_base <= '0;
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_we   <= w_accept;
      r_done <= w_finish;
      if (w_start) begin
        r_n        <= out_size;
        r_x        <= '0;
        r_row_base <= base_addr;
        r_cnt      <= '0;
        r_err      <= 1'b0;
      end
      if (w_accept) begin
        r_addr  <= r_row_base + AWIDTH'(r_x);
        r_wdata <= in_data;
        r_cnt   <= r_cnt + CNT_ONE;
        if (r_x == r_n - X_ONE) begin
          r_x        <= '0;
          r_row_base <= r_row_base + w_stride;
        end else begin
          r_x <= r_x + X_ONE;
        end
      end
      if (w_ovf || (w_finish && !w_count_ok)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = (r_state == S_ACTIVE);
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_ctrl_pool_wb.sv
// Bench for ctrl_pool_wb: frame-level reference model compared every cycle, plus literal write logs.
module tb_ctrl_pool_wb;

  logic        clk = 1'b0;
  logic        xrst;
  logic        in_begin, in_valid, in_end;
  logic [15:0] in_data;
  logic [9:0]  out_size;
  logic [11:0] base_addr;
  logic [9:0]  out_pitch;
  logic        mem_we, busy, done, err;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;

  ctrl_pool_wb dut (
    .clk(clk), .xrst(xrst), .in_begin(in_begin), .in_valid(in_valid), .in_end(in_end),
    .in_data(in_data), .out_size(out_size), .base_addr(base_addr), .out_pitch(out_pitch),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: address of pixel k is base + (k/N)*stride + k%N, mod 2^12.
  logic        m_active = 1'b0;
  int          m_n, m_base, m_stride, m_cnt;
  logic        e_we = 1'b0, e_done = 1'b0, e_err = 1'b0, e_busy = 1'b0;
  logic [11:0] e_addr = '0;
  logic [15:0] e_wdata = '0;

  always @(posedge clk) begin
    int a;
    if (xrst) begin
      m_active = 1'b0; m_cnt = 0;
      e_we = 1'b0; e_done = 1'b0; e_err = 1'b0;
    end else begin
      e_we = 1'b0; e_done = 1'b0;
      if (!m_active) begin
        if (in_begin) begin
          m_active = 1'b1;
          m_n      = int'(out_size);
          m_base   = int'(base_addr);
`ifdef CTRL_POOL_WB_PITCH_EN
          m_stride = int'(out_pitch);
`else
          m_stride = int'(out_size);
`endif
          m_cnt    = 0;
          e_err    = 1'b0;
        end
      end else begin
        if (in_valid) begin
          if (m_cnt < m_n * m_n) begin
            a       = m_base + (m_cnt / m_n) * m_stride + (m_cnt % m_n);
            e_we    = 1'b1;
            e_addr  = a[11:0];
            e_wdata = in_data;
            m_cnt++;
          end else begin
            e_err = 1'b1;
          end
        end
        if (in_end) begin
          e_done = 1'b1;
          if (m_cnt != m_n * m_n) e_err = 1'b1;
          m_active = 1'b0;
        end
      end
    end
    e_busy = m_active;
  end

  logic [11:0] cap_addr[$];
  logic [15:0] cap_data[$];
  logic        cap_done[$];
  int          done_cnt = 0;

  always begin
    @(posedge clk);
    #1;
    if (chk_en) begin
      chk("mem_we", 32'(mem_we), 32'(e_we));
      chk("busy",   32'(busy),   32'(e_busy));
      chk("done",   32'(done),   32'(e_done));
      chk("err",    32'(err),    32'(e_err));
      if (e_we) begin
        chk("mem_addr",  32'(mem_addr),  32'(e_addr));
        chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
      end
    end
    if (mem_we === 1'b1) begin
      cap_addr.push_back(mem_addr);
      cap_data.push_back(mem_wdata);
      cap_done.push_back(done);
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic cyc(input logic b, input logic v, input logic e, input logic [15:0] d);
    in_begin = b; in_valid = v; in_end = e; in_data = d;
    @(negedge clk);
    in_begin = 1'b0; in_valid = 1'b0; in_end = 1'b0; in_data = '0;
  endtask

  task automatic setup(input int n, input int b, input int p);
    out_size  = 10'(n);
    base_addr = 12'(b);
    out_pitch = 10'(p);
    cap_addr.delete(); cap_data.delete(); cap_done.delete();
    done_cnt = 0;
  endtask

  task automatic idle(input int k);
    repeat (k) cyc(1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    xrst = 1'b1; in_begin = 1'b0; in_valid = 1'b0; in_end = 1'b0; in_data = '0;
    out_size = '0; base_addr = '0; out_pitch = '0;
    repeat (3) @(negedge clk);
    chk("rst_we",    32'(mem_we),    32'h0);
    chk("rst_addr",  32'(mem_addr),  32'h0);
    chk("rst_wdata", 32'(mem_wdata), 32'h0);
    chk("rst_busy",  32'(busy),      32'h0);
    chk("rst_done",  32'(done),      32'h0);
    chk("rst_err",   32'(err),       32'h0);
    chk_en = 1'b1;
    xrst = 1'b0;
    idle(2);

    // Basic frame, end coincident with last pixel
    setup(2, 'h100, 2);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 1); cyc(0, 1, 0, 2); cyc(0, 1, 0, 3); cyc(0, 1, 1, 4);
    idle(2);
    chk("t1_nwr", 32'(cap_addr.size()), 32'd4);
    for (int i = 0; i < 4 && i < cap_addr.size(); i++) begin
      chk("t1_addr", 32'(cap_addr[i]), 32'h100 + 32'(i));
      chk("t1_data", 32'(cap_data[i]), 32'(i + 1));
    end
    if (cap_done.size() == 4) chk("t1_done_with_last", 32'(cap_done[3]), 32'h1);
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    chk("t1_err", 32'(err), 32'h0);

    // Row stride
    setup(2, 0, 8);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 5); cyc(0, 1, 0, 6); cyc(0, 1, 0, 7); cyc(0, 1, 0, 8);
    cyc(0, 0, 1, 0);
    idle(2);
    chk("t2_nwr", 32'(cap_addr.size()), 32'd4);
    if (cap_addr.size() == 4) begin
`ifdef CTRL_POOL_WB_PITCH_EN
      chk("t2_addr2", 32'(cap_addr[2]), 32'h8);
      chk("t2_addr3", 32'(cap_addr[3]), 32'h9);
`else
      chk("t2_addr2", 32'(cap_addr[2]), 32'h2);
      chk("t2_addr3", 32'(cap_addr[3]), 32'h3);
`endif
      chk("t2_addr1", 32'(cap_addr[1]), 32'h1);
    end
    chk("t2_err", 32'(err), 32'h0);

    // Overflow: 5 pixels into a 2x2 frame
    setup(2, 'h20, 2);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 16'(10 + i));
    cyc(0, 0, 1, 0);
    idle(2);
    chk("t3_nwr", 32'(cap_addr.size()), 32'd4);
    chk("t3_err", 32'(err), 32'h1);
    chk("t3_done_cnt", 32'(done_cnt), 32'd1);

    // Underflow: 7 pixels into a 3x3 frame, next begin clears err
    setup(3, 'h200, 3);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 1, 0, 16'(20 + i));
    cyc(0, 0, 1, 0);
    idle(1);
    chk("t4_nwr", 32'(cap_addr.size()), 32'd7);
    if (cap_addr.size() == 7) chk("t4_addr6", 32'(cap_addr[6]), 32'h206);
    chk("t4_err", 32'(err), 32'h1);
    cyc(1, 0, 0, 0);
    chk("t4_err_clr", 32'(err), 32'h0);
    chk("t4_busy", 32'(busy), 32'h1);
    cyc(0, 0, 1, 0);
    idle(1);

    // Second begin mid-frame is ignored
    setup(2, 'h100, 2);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 1); cyc(0, 1, 0, 2);
    base_addr = 12'h300;
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 3); cyc(0, 1, 1, 4);
    idle(2);
    chk("t5_nwr", 32'(cap_addr.size()), 32'd4);
    if (cap_addr.size() == 4) begin
      chk("t5_addr2", 32'(cap_addr[2]), 32'h102);
      chk("t5_addr3", 32'(cap_addr[3]), 32'h103);
    end
    chk("t5_err", 32'(err), 32'h0);

    // Reset mid-frame squashes a pending pixel; dropped pixels in wait; restart at base
    setup(2, 'h40, 2);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 1); cyc(0, 1, 0, 2);
    xrst = 1'b1;
    cyc(0, 1, 0, 3);
    xrst = 1'b0;
    chk("t6_busy", 32'(busy), 32'h0);
    cyc(0, 1, 0, 4); cyc(0, 1, 0, 5); cyc(0, 0, 1, 0);
    idle(1);
    chk("t6_nwr", 32'(cap_addr.size()), 32'd2);
    chk("t6_done_cnt", 32'(done_cnt), 32'd0);
    cyc(1, 1, 0, 7);
    cyc(0, 1, 0, 9);
    idle(1);
    chk("t6_nwr2", 32'(cap_addr.size()), 32'd3);
    if (cap_addr.size() == 3) begin
      chk("t6_restart_addr", 32'(cap_addr[2]), 32'h40);
      chk("t6_restart_data", 32'(cap_data[2]), 32'h9);
    end
    cyc(0, 1, 0, 10); cyc(0, 1, 0, 11); cyc(0, 1, 1, 12);
    idle(2);
    chk("t6_err", 32'(err), 32'h0);

    // Silent address wrap
    setup(2, 'hFFE, 2);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 1); cyc(0, 1, 0, 2); cyc(0, 1, 0, 3); cyc(0, 1, 1, 4);
    idle(2);
    chk("t7_nwr", 32'(cap_addr.size()), 32'd4);
    if (cap_addr.size() == 4) begin
      chk("t7_addr1", 32'(cap_addr[1]), 32'hFFF);
      chk("t7_addr2", 32'(cap_addr[2]), 32'h000);
    end
    chk("t7_err", 32'(err), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
